sd4_mac_accumulator: RTL and testbench
======================================

Name: sd4_mac_accumulator

Overview:
- Downstream stage of the SD4 MAC adder tree. Consumes one 20-bit signed partial-product sum per beat and accumulates a programmable number of beats (one dot-product vector).
- Presents the final accumulated result on a valid/ready output handshake.
- Provides optional saturation and a sticky per-vector overflow flag.

Parameters:
- IN_W, 20, width of the signed input sum from the adder tree.
- ACC_W, 32, width of the accumulator and result (must be >= IN_W+1).
- CNT_W, 8, width of the vector-length field.
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a vector; sampled only in IDLE.
- cfg_len  in  CNT_W  number of beats in the vector; latched on an accepted start.
- in_valid  in  1  signed_sum is valid.
- in_ready  out  1  block accepts a beat this cycle.
- signed_sum  in  IN_W  signed sum from the adder tree.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- acc_out  out  ACC_W  signed accumulated result.
- ovf  out  1  at least one add in this vector overflowed; valid while out_valid=1.
- busy  out  1  high in ACC or OUT.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - acc=0, remaining count=0.
  - acc_out=0, out_valid=0, in_ready=0, ovf=0, busy=0.
  - Reset takes effect immediately, including mid-vector or mid-OUT; any partial result is discarded.
- States: IDLE, ACC, OUT (one-hot or binary, implementer's choice).
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1 with cfg_len>0: acc<=0, ovf<=0, remaining<=cfg_len, go to ACC.
  - On start=1 with cfg_len=0: acc<=0, ovf<=0, go directly to OUT; the result is 0 and out_valid rises on the next cycle.
- ACC:
  - in_ready=1.
  - A beat transfers when in_valid & in_ready are both high. On a transfer, acc<=f(acc + sext(signed_sum)) and remaining<=remaining-1.
  - Cycles with in_valid=0 leave acc and remaining unchanged.
  - The transfer with remaining=1 is the last beat; the next state is OUT.
  - start is ignored in ACC.
- Add rule:
  - Compute the sum at ACC_W+1 bits.
  - Overflow means the sum lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - SATURATE=1: clamp to the nearest bound. SATURATE=0: keep the low ACC_W bits.
  - Either way, ovf<=1 on overflow (sticky until the next start).
- OUT:
  - out_valid=1, acc_out=acc, in_ready=0.
  - acc_out and ovf are held stable until out_ready=1.
  - On out_valid & out_ready: go to IDLE and drop out_valid the next cycle.
  - start is ignored in OUT, including in the handshake cycle.
  - Latency: out_valid rises exactly 1 cycle after the last beat transfers.
- acc_out is registered; there is no combinational path from in_* to out_*.
- acc_out retains its last value in IDLE; it is not cleared after the handshake.
- Throughput: back-to-back vectors need at least one IDLE cycle between the result handshake and the next start.

Decomposition:
- Shared package sd4_mac_pkg holds:
  - the state enum (IDLE/ACC/OUT);
  - the IN_W and ACC_W default constants;
  - saturation bound constants (ACC_MAX, ACC_MIN).
- One natural sub-module, sd4_sat_add: a combinational ACC_W + IN_W signed add with overflow detect and a SATURATE-controlled clamp.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Reset values: assert rst_n=0 mid-ACC after 2 of 4 beats -> all outputs 0 immediately, state IDLE. A fresh start with cfg_len=2 and beats 5, 6 -> acc_out=11.
- Basic vector: start, cfg_len=3, beats 100, -50, 7 with no gaps -> out_valid one cycle after beat 3, acc_out=57, ovf=0.
- Gaps and backpressure:
  - cfg_len=4, beats -524288 ×4 with in_valid deasserted for 2 cycles between beats -> acc_out=-2097152.
  - Hold out_ready=0 for 5 cycles -> out_valid and acc_out stay stable; in_ready=0 throughout.
- Saturation (ACC_W=21, SATURATE=1): cfg_len=3, beats 524287 ×3 -> acc_out=1048575, ovf=1.
- Wrap (SATURATE=0): same stimulus -> acc_out=-524291, ovf=1.
- Corner cases:
  - cfg_len=0 -> acc_out=0, out_valid on the next cycle.
  - start pulsed during ACC and during OUT -> ignored; the count is not restarted.
  - cfg_len=255 of +1 -> acc_out=255.

Source files
------------

// File: rtl/sd4_mac_pkg.sv
// Shared types and constants for the SD4 MAC accumulator stage.
package sd4_mac_pkg;

    localparam int unsigned IN_W_DEF  = 20;
    localparam int unsigned ACC_W_DEF = 32;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_OUT
    } state_e;

endpackage

// File: rtl/sd4_sat_add.sv
// Signed accumulator + input add with overflow detect and optional clamp.
module sd4_sat_add
    import sd4_mac_pkg::*;
#(
    parameter int unsigned IN_W     = IN_W_DEF,
    parameter int unsigned ACC_W    = ACC_W_DEF,
    parameter bit          SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [IN_W-1:0]  add_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    logic [ACC_W:0] sum_wide;
    logic           ovf;

    always_comb begin
        sum_wide = {acc_i[ACC_W-1], acc_i}
                 + {{(ACC_W+1-IN_W){add_i[IN_W-1]}}, add_i};
        // Result out of range exactly when the two top bits of the wide sum disagree.
        ovf   = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        sum_o = sum_wide[ACC_W-1:0];
        if (SATURATE && ovf) begin
            sum_o = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end
        ovf_o = ovf;
    end

endmodule

// File: rtl/sd4_mac_accumulator.sv
// Accumulates a programmable number of signed beats per vector and presents
// the result on a valid/ready handshake with a sticky overflow flag.
module sd4_mac_accumulator
    import sd4_mac_pkg::*;
#(
    parameter int unsigned IN_W     = IN_W_DEF,
    parameter int unsigned ACC_W    = ACC_W_DEF,
    parameter int unsigned CNT_W    = 8,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  signed_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] acc_out_q, acc_out_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    sd4_sat_add #(
        .IN_W     (IN_W),
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .acc_i (acc_q),
        .add_i (signed_sum),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_out_d = acc_out_q;
        rem_d     = rem_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (cfg_len != '0) begin
                        rem_d   = cfg_len;
                        state_d = ST_ACC;
                    end else begin
                        acc_out_d = '0;
                        state_d   = ST_OUT;
                    end
                end
            end
            ST_ACC: begin
                if (in_valid) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_ovf;
                    rem_d = rem_q - CNT_W'(1);
                    // Result register loads alongside the last beat so out_valid
                    // and acc_out appear together one cycle after the transfer.
                    if (rem_q == CNT_W'(1)) begin
                        acc_out_d = add_sum;
                        state_d   = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            acc_out_q <= '0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_out_q <= acc_out_d;
            rem_q     <= rem_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);
    assign acc_out   = acc_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sd4_mac_accumulator.sv
// Bench for sd4_mac_accumulator: three instances (32-bit saturating, 21-bit
// saturating, 21-bit wrapping) driven in lock-step and checked against a model.
module tb_sd4_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic [19:0] signed_sum;
    logic        out_ready;

    logic        ir_a, ov_a, by_a, of_a;
    logic        ir_b, ov_b, by_b, of_b;
    logic        ir_c, ov_c, by_c, of_c;
    logic [31:0] acc_a;
    logic [20:0] acc_b;
    logic [20:0] acc_c;

    int total = 0;
    int bad   = 0;
    int vb [256];

    always #5 clk = ~clk;

    sd4_mac_accumulator #(.IN_W(20), .ACC_W(32), .CNT_W(8), .SATURATE(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(ir_a), .signed_sum(signed_sum),
        .out_valid(ov_a), .out_ready(out_ready), .acc_out(acc_a), .ovf(of_a), .busy(by_a));

    sd4_mac_accumulator #(.IN_W(20), .ACC_W(21), .CNT_W(8), .SATURATE(1'b1)) dut21s (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(ir_b), .signed_sum(signed_sum),
        .out_valid(ov_b), .out_ready(out_ready), .acc_out(acc_b), .ovf(of_b), .busy(by_b));

    sd4_mac_accumulator #(.IN_W(20), .ACC_W(21), .CNT_W(8), .SATURATE(1'b0)) dut21w (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(ir_c), .signed_sum(signed_sum),
        .out_valid(ov_c), .out_ready(out_ready), .acc_out(acc_c), .ovf(of_c), .busy(by_c));

    typedef struct {
        int     len;
        int     beats [4];
        int     gap;
        int     stall;
        longint e32, e21s, e21w;
        bit     o32, o21s, o21w;
    } vec_t;

    vec_t tbl [5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_res(input string nm, input longint e32, input longint e21s,
                           input longint e21w, input bit o32, input bit o21s, input bit o21w);
        chk({nm, "_acc32"},  longint'($signed(acc_a)), e32);
        chk({nm, "_acc21s"}, longint'($signed(acc_b)), e21s);
        chk({nm, "_acc21w"}, longint'($signed(acc_c)), e21w);
        chk({nm, "_ovf32"},  longint'(of_a), longint'(o32));
        chk({nm, "_ovf21s"}, longint'(of_b), longint'(o21s));
        chk({nm, "_ovf21w"}, longint'(of_c), longint'(o21w));
    endtask

    // Reference: fold the beats with ordinary integer arithmetic, then clamp or
    // wrap into the w-bit signed range whenever the running sum leaves it.
    function automatic void model(input int w, input bit sat, input int n,
                                  output longint r, output bit o);
        longint mx;
        longint mn;
        longint s;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -mx - 1;
        r  = 0;
        o  = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = r + longint'(vb[i]);
            if (s > mx) begin
                o = 1'b1;
                r = sat ? mx : s - (longint'(1) <<< w);
            end else if (s < mn) begin
                o = 1'b1;
                r = sat ? mn : s + (longint'(1) <<< w);
            end else begin
                r = s;
            end
        end
    endfunction

    task automatic run_vec(input int len, input int gap, input int stall,
                           input longint e32, input longint e21s, input longint e21w,
                           input bit o32, input bit o21s, input bit o21w);
        start   = 1'b1;
        cfg_len = len[7:0];
        tick();
        start = 1'b0;
        chk("busy_after_start", longint'(by_a), 1);
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            chk("in_ready_acc", longint'(ir_a), 1);
            chk("no_early_valid", longint'(ov_a), 0);
            in_valid   = 1'b1;
            signed_sum = vb[i][19:0];
            tick();
        end
        in_valid = 1'b0;
        chk("latency_valid", longint'(ov_a), 1);
        chk("in_ready_out", longint'(ir_a), 0);
        chk_res("result", e32, e21s, e21w, o32, o21s, o21w);
        repeat (stall) begin
            out_ready = 1'b0;
            tick();
            chk("stall_valid", longint'(ov_a), 1);
            chk("stall_in_ready", longint'(ir_a), 0);
            chk("stall_acc", longint'($signed(acc_a)), e32);
            chk("stall_ovf21s", longint'(of_b), longint'(o21s));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("after_hs_valid", longint'(ov_a), 0);
        chk("after_hs_busy", longint'(by_a), 0);
        chk("retain_acc", longint'($signed(acc_a)), e32);
    endtask

    initial begin
        longint r32, r21s, r21w;
        bit     v32, v21s, v21w;
        int     n;

        rst_n      = 1'b0;
        start      = 1'b0;
        cfg_len    = '0;
        in_valid   = 1'b0;
        signed_sum = '0;
        out_ready  = 1'b0;

        tbl[0] = '{3, '{100, -50, 7, 0}, 0, 0, 57, 57, 57, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{4, '{-524288, -524288, -524288, -524288}, 2, 5,
                   -2097152, -1048576, 0, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{0, '{0, 0, 0, 0}, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{3, '{524287, 524287, 524287, 0}, 0, 0,
                   1572861, 1048575, -524291, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{2, '{5, 6, 0, 0}, 0, 0, 11, 11, 11, 1'b0, 1'b0, 1'b0};

        #12;
        chk("rst_out_valid", longint'(ov_a), 0);
        chk("rst_in_ready", longint'(ir_a), 0);
        chk("rst_busy", longint'(by_a), 0);
        chk_res("rst", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 4; i++) vb[i] = tbl[t].beats[i];
            run_vec(tbl[t].len, tbl[t].gap, tbl[t].stall,
                    tbl[t].e32, tbl[t].e21s, tbl[t].e21w,
                    tbl[t].o32, tbl[t].o21s, tbl[t].o21w);
        end

        // Asynchronous reset in the middle of a vector, after 2 of 4 beats.
        start   = 1'b1;
        cfg_len = 8'd4;
        tick();
        start      = 1'b0;
        in_valid   = 1'b1;
        signed_sum = 20'd1000;
        tick();
        signed_sum = 20'd2000;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", longint'(by_a), 0);
        chk("midrst_in_ready", longint'(ir_a), 0);
        chk("midrst_out_valid", longint'(ov_a), 0);
        chk_res("midrst", 0, 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) vb[i] = tbl[4].beats[i];
        run_vec(tbl[4].len, tbl[4].gap, tbl[4].stall,
                tbl[4].e32, tbl[4].e21s, tbl[4].e21w,
                tbl[4].o32, tbl[4].o21s, tbl[4].o21w);

        // start pulses during ACC and OUT (including the handshake cycle) are ignored.
        start   = 1'b1;
        cfg_len = 8'd3;
        tick();
        start      = 1'b0;
        in_valid   = 1'b1;
        signed_sum = 20'd10;
        tick();
        in_valid = 1'b0;
        start    = 1'b1;
        cfg_len  = 8'd1;
        tick();
        start = 1'b0;
        chk("ign_acc_in_ready", longint'(ir_a), 1);
        in_valid   = 1'b1;
        signed_sum = 20'd20;
        tick();
        chk("ign_acc_no_restart", longint'(ov_a), 0);
        signed_sum = 20'd30;
        tick();
        in_valid = 1'b0;
        chk("ign_latency", longint'(ov_a), 1);
        chk_res("ign", 60, 60, 60, 1'b0, 1'b0, 1'b0);
        start   = 1'b1;
        cfg_len = 8'd2;
        tick();
        chk("ign_out_valid", longint'(ov_a), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("ign_hs_valid", longint'(ov_a), 0);
        chk("ign_hs_busy", longint'(by_a), 0);
        tick();
        chk("ign_idle_busy", longint'(by_a), 0);

        // Longest vector: 255 beats of +1.
        for (int i = 0; i < 255; i++) vb[i] = 1;
        run_vec(255, 0, 0, 255, 255, 255, 1'b0, 1'b0, 1'b0);

        // Random vectors, half the beats drawn from the extremes to provoke overflow.
        for (int k = 0; k < 24; k++) begin
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 0)
                    vb[i] = ($urandom_range(0, 1) == 0) ? 524287 : -524288;
                else
                    vb[i] = int'($urandom_range(0, 1048575)) - 524288;
            end
            model(32, 1'b1, n, r32, v32);
            model(21, 1'b1, n, r21s, v21s);
            model(21, 1'b0, n, r21w, v21w);
            run_vec(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    r32, r21s, r21w, v32, v21s, v21w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
